// File: rtl/i2c_slave_regfile_if.sv
// Register-file side of the I2C slave: register image, write strobe and busy flag.
// slave modport drives regs_o/wr_pulse/wr_idx/busy; master modport observes them.
`timescale 1ns/1ps

interface i2c_slave_regfile_if #(
    parameter int NUM_REGS = 4
);
    logic [NUM_REGS*8-1:0]       regs_o;
    logic                        wr_pulse;
    logic [$clog2(NUM_REGS)-1:0] wr_idx;
    logic                        busy;

    modport slave (
        output regs_o,
        output wr_pulse,
        output wr_idx,
        output busy
    );

    modport master (
        input regs_o,
        input wr_pulse,
        input wr_idx,
        input busy
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS 8-bit registers with an auto-incrementing pointer.
// Ports: clk, reset (sync, active high), SCL in, SDA open-drain inout, host bundle out.
`timescale 1ns/1ps

module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR  = 7'h24,
    parameter int         NUM_REGS  = 4,
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCL,
    inout  wire                  SDA,
    i2c_slave_regfile_if.slave   host
);

    localparam int PW = $clog2(NUM_REGS);
    localparam logic [8:0]    NREG9 = 9'(NUM_REGS);
    localparam logic [PW-1:0] LAST  = PW'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT
    } state_t;

    state_t        state;
    logic [1:0]    scl_sync;
    logic [1:0]    sda_sync;
    logic          scl_q;
    logic          sda_q;
    logic          scl_s;
    logic          sda_s;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          sda_low;
    logic          wr_pulse_q;
    logic [PW-1:0] wr_idx_q;
    logic          busy_q;
    logic [7:0]    regs [NUM_REGS];

    assign SDA = sda_low ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign ptr_nxt   = (ptr == LAST) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            sda_low    <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            busy_q     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= REG_RESET;
            end
        end else begin
            wr_pulse_q <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                busy_q  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_low <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, WAIT: begin
                        sda_low <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shreg[7:1] == SLV_ADDR) begin
                                sda_low <= 1'b1;
                                busy_q  <= 1'b1;
                                state   <= ADDR_ACK;
                            end else begin
                                state   <= WAIT;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (shreg[0]) begin
                                // Read: first data bit goes out on this same fall.
                                shreg   <= regs[ptr];
                                sda_low <= ~regs[ptr][7];
                                state   <= RDATA;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if ({1'b0, shreg} < NREG9) begin
                                ptr     <= shreg[PW-1:0];
                                sda_low <= 1'b1;
                                state   <= PTR_ACK;
                            end else begin
                                busy_q  <= 1'b0;
                                state   <= WAIT;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            regs[ptr]  <= shreg;
                            wr_pulse_q <= 1'b1;
                            wr_idx_q   <= ptr;
                            ptr        <= ptr_nxt;
                            sda_low    <= 1'b1;
                            state      <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                state   <= RDATA_ACK;
                            end else begin
                                sda_low <= ~shreg[6];
                                shreg   <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        // Master ACK is sampled on the rise; the next byte
                        // starts on the following fall.
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr    <= ptr_nxt;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= WAIT;
                            end
                        end else if (scl_fall) begin
                            shreg   <= regs[ptr];
                            sda_low <= ~regs[ptr][7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    default: begin
                        sda_low <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign host.regs_o[8*k +: 8] = regs[k];
    end

    assign host.wr_pulse = wr_pulse_q;
    assign host.wr_idx   = wr_idx_q;
    assign host.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: bit-banged I2C master plus a
// register/pointer reference model, directed cases then random transactions.
`timescale 1ns/1ps

module tb_i2c_slave_regfile;

    localparam int         N  = 4;
    localparam logic [6:0] SA = 7'h24;
    localparam logic [7:0] RR = 8'h3C;
    localparam time        Q  = 50;
    localparam time        H  = 100;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic scl       = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regfile_if #(.NUM_REGS(N)) host ();

    i2c_slave_regfile #(
        .SLV_ADDR  (SA),
        .NUM_REGS  (N),
        .REG_RESET (RR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .SCL   (scl),
        .SDA   (sda_bus),
        .host  (host)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] mregs [N];
    int         mptr;
    int         wr_log  [$];
    int         exp_log [$];
    logic [7:0] wdat    [4];

    always @(posedge clk) begin
        if (host.wr_pulse === 1'b1) wr_log.push_back(int'(host.wr_idx));
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #H;
        m_sda_low = 1'b1; #H;
        scl = 1'b0;       #Q;
    endtask

    task automatic i2c_stop;
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #H;
        m_sda_low = 1'b0; #H;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda_low = ~b[i]; #Q;
            scl = 1'b1;        #H;
            scl = 1'b0;        #Q;
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #(H/2);
        ack = (sda_bus === 1'b0);
        #(H/2);
        scl = 1'b0;       #Q;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] b);
        b = '0;
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #Q;
            scl = 1'b1; #(H/2);
            b[i] = sda_bus;
            #(H/2);
            scl = 1'b0; #Q;
        end
        m_sda_low = mack; #Q;
        scl = 1'b1;       #H;
        scl = 1'b0;       #Q;
        m_sda_low = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_reg%0d", tag, k),
                32'(host.regs_o[8*k +: 8]), 32'(mregs[k]));
        end
        chk({tag, "_busy"}, 32'(host.busy), 32'd0);
        chk({tag, "_sda_idle"}, 32'(sda_bus), 32'd1);
        chk({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++) begin
            chk($sformatf("%s_wridx%0d", tag, i),
                32'(wr_log[i]), 32'(exp_log[i]));
        end
        wr_log.delete();
        exp_log.delete();
    endtask

    task automatic do_write(input logic [7:0] p, input int n, input string tag);
        logic a;
        bit   ok;
        ok = (int'(p) < N);
        i2c_start;
        wr_byte({SA, 1'b0}, a);
        chk({tag, "_addr_ack"}, 32'(a), 32'd1);
        chk({tag, "_busy_on"}, 32'(host.busy), 32'd1);
        wr_byte(p, a);
        chk({tag, "_ptr_ack"}, 32'(a), 32'(ok));
        if (ok) mptr = int'(p);
        for (int i = 0; i < n; i++) begin
            wr_byte(wdat[i], a);
            chk($sformatf("%s_data_ack%0d", tag, i), 32'(a), 32'(ok));
            if (ok) begin
                mregs[mptr] = wdat[i];
                exp_log.push_back(mptr);
                mptr = (mptr + 1) % N;
            end
        end
        i2c_stop;
        check_state(tag);
    endtask

    task automatic do_read(input bit set_ptr, input logic [7:0] p,
                           input int n, input string tag);
        logic       a;
        logic [7:0] b;
        i2c_start;
        if (set_ptr) begin
            wr_byte({SA, 1'b0}, a);
            chk({tag, "_waddr_ack"}, 32'(a), 32'd1);
            wr_byte(p, a);
            chk({tag, "_ptr_ack"}, 32'(a), 32'(int'(p) < N));
            if (int'(p) < N) mptr = int'(p);
            i2c_start;
        end
        wr_byte({SA, 1'b1}, a);
        chk({tag, "_raddr_ack"}, 32'(a), 32'd1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i < n - 1, b);
            chk($sformatf("%s_data%0d", tag, i), 32'(b), 32'(mregs[mptr]));
            if (i < n - 1) mptr = (mptr + 1) % N;
        end
        chk({tag, "_sda_rel"}, 32'(sda_bus), 32'd1);
        i2c_stop;
        check_state(tag);
    endtask

    task automatic do_badaddr(input logic [6:0] ad, input string tag);
        logic a;
        i2c_start;
        wr_byte({ad, 1'($urandom_range(0, 1))}, a);
        chk({tag, "_nack"}, 32'(a), 32'd0);
        chk({tag, "_busy_off"}, 32'(host.busy), 32'd0);
        wr_byte(8'($urandom), a);
        chk({tag, "_ignored"}, 32'(a), 32'd0);
        i2c_stop;
        check_state(tag);
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        logic [6:0] ad;
        int         op;

        for (int k = 0; k < N; k++) mregs[k] = RR;
        mptr = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", 32'(host.busy), 32'd0);
        chk("rst_wr_pulse", 32'(host.wr_pulse), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(negedge clk);
        check_state("rst");

        wdat[0] = 8'hA5; wdat[1] = 8'h5A;
        do_write(8'h01, 2, "wr_basic");

        wdat[0] = 8'h11; wdat[1] = 8'h22;
        do_write(8'h03, 2, "wr_wrap");
        do_read(1'b1, 8'h03, 2, "rd_comb");

        do_badaddr(7'h25, "bad_4a");
        do_badaddr(7'h00, "gen_call");

        wdat[0] = 8'h77; wdat[1] = 8'h66;
        do_write(8'h04, 2, "ptr_oob");
        do_read(1'b0, 8'h00, 2, "rd_cur");

        i2c_start;
        wr_byte({SA, 1'b0}, a);
        chk("part_addr_ack", 32'(a), 32'd1);
        wr_byte(8'h00, a);
        chk("part_ptr_ack", 32'(a), 32'd1);
        mptr = 0;
        send_bits(8'hFF, 4);
        i2c_stop;
        check_state("partial");
        do_read(1'b0, 8'h00, 1, "after_part");

        for (int t = 0; t < 18; t++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
                do_write(8'($urandom_range(0, 5)), $urandom_range(1, 4),
                         $sformatf("rnd%0d_wr", t));
            end else if (op == 1) begin
                do_read(1'b1, 8'($urandom_range(0, 5)), $urandom_range(1, 5),
                        $sformatf("rnd%0d_rdc", t));
            end else if (op == 2) begin
                do_read(1'b0, 8'h00, $urandom_range(1, 5),
                        $sformatf("rnd%0d_rd", t));
            end else begin
                ad = 7'($urandom_range(0, 127));
                if (ad == SA) ad = ad ^ 7'h01;
                do_badaddr(ad, $sformatf("rnd%0d_bad", t));
            end
        end

        wdat[0] = 8'hC7;
        do_write(8'h02, 1, "pre_rst");
        i2c_start;
        send_bits({SA, 1'b1}, 8);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #(H/2);
        chk("rst_mid_ack", 32'(sda_bus), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_sda", 32'(sda_bus), 32'd1);
        for (int k = 0; k < N; k++) mregs[k] = RR;
        mptr = 0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_mid_reg%0d", k),
                32'(host.regs_o[8*k +: 8]), 32'(RR));
        end
        chk("rst_mid_busy", 32'(host.busy), 32'd0);
        reset = 1'b0;
        #(H/2);
        scl = 1'b0; #Q;
        rd_byte(1'b0, b);
        chk("rst_ignored", 32'(b), 32'hFF);
        i2c_stop;
        wr_log.delete();
        check_state("post_rst");
        do_read(1'b0, 8'h00, 1, "post_rst_rd");

        wdat[0] = 8'h9E; wdat[1] = 8'h01;
        do_write(8'h00, 2, "post_rst_wr");
        do_read(1'b1, 8'h00, 3, "post_rst_rdc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h24: 7-bit slave address.
REQ-002 SHALL have parameter NUM_REGS, default 4: number of 8-bit registers, range 2..128.
REQ-003 SHALL have parameter REG_RESET, default 8'h00: reset value of every register.
REQ-004 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port SCL, input, 1: I2C clock from the master, asynchronous to clk.
REQ-007 SHALL have port SDA, inout, 1: I2C data, open-drain; drives only 0, otherwise high-Z.
REQ-008 SHALL have port regs_o, output, NUM_REGS*8: register file, register k at bits [8k+7:8k].
REQ-009 SHALL have port wr_pulse, output, 1: one-clk pulse per register write committed over I2C.
REQ-010 SHALL have port wr_idx, output, $clog2(NUM_REGS): index of the register written; valid while wr_pulse is high.
REQ-011 SHALL have port busy, output, 1: high from an address match until the next STOP, START or NACK.

Function
REQ-012 SHALL pass SCL and SDA through 2-FF synchronizers; all edge, START and STOP detection uses the synchronized copies only.
REQ-013 SHALL detect START as a synced SDA fall while synced SCL is high, and STOP as a synced SDA rise while synced SCL is high.
REQ-014 SHALL give START priority over every other event: a START in any state goes to ADDR and clears the bit counter (repeated start).
REQ-015 SHALL make a STOP in any state go to IDLE and discard any partial byte, with no register write.
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT.
REQ-017 SHALL sample SDA on the synced SCL rise, MSB first, 8 bits per byte.
REQ-018 SHALL, on the SCL fall ending bit 8 of ADDR, ACK if addr[7:1]==SLV_ADDR; otherwise (including general call 0x00) go to WAIT with SDA released.
REQ-019 SHALL drive an ACK as SDA low from the synced SCL fall ending bit 8 until the synced SCL fall ending bit 9, then release it in the same clk cycle.
REQ-020 SHALL, after an ACKed address with R/W=0, take the next byte as the register pointer.
REQ-021 SHALL ACK a pointer below NUM_REGS and load it; a pointer of NUM_REGS or above gets a NACK, leaves the pointer unchanged and goes to WAIT.
REQ-022 SHALL, for each later write byte: at the SCL fall ending bit 8, write regs[ptr], assert wr_pulse with wr_idx=ptr for exactly 1 clk, ACK, and advance ptr by 1.
REQ-023 SHALL, after an ACKed address with R/W=1, shift regs[ptr] out MSB first, changing SDA only on a synced SCL fall, with the first bit driven at the fall that ends the address ACK.
REQ-024 SHALL sample the master ACK bit on the 9th SCL rise of a read byte: on ACK advance ptr and send the next byte; on NACK release SDA and go to WAIT.
REQ-025 SHALL wrap the pointer from NUM_REGS-1 to 0 on both read and write.
REQ-026 SHALL keep the pointer across a repeated START and across a STOP, so that a write-pointer, Sr, read sequence works.
REQ-027 SHALL, in WAIT, ignore everything except START and STOP.
REQ-028 SHALL hold regs_o constant except for the writes in REQ-022.
REQ-029 SHALL require SCL high and low phases of at least 4 clk periods each; behaviour below that is undefined.

Reset
REQ-030 SHALL, while reset is high at a clk edge, force: state=IDLE, SDA released, every register=REG_RESET, ptr=0, wr_pulse=0, busy=0.
REQ-031 SHALL, on reset mid-transaction, release SDA by the next clk and make the block ignore the bus until a new START.

Verification
REQ-032 Write: S, 0x48, 0x01, 0xA5, 0x5A, P -> ACKs on all bytes; reg1=A5, reg2=5A; two wr_pulse with wr_idx 1, then 2.
REQ-033 Combined read: S 0x48 0x03 Sr 0x49, read 2 bytes (ACK, NACK), P -> data reg3 then reg0 (wrap); SDA released after the NACK.
REQ-034 Address 0x4A -> no ACK, regs unchanged, busy=0, no wr_pulse.
REQ-035 Pointer 0x04 with NUM_REGS=4 -> NACK, ptr unchanged, following bytes ignored.
REQ-036 STOP after 4 bits of a data byte -> no write, state IDLE; the next transaction works normally.
REQ-037 Reset asserted during a read ACK -> SDA high-Z next clk, all registers=REG_RESET, ptr=0.
